// File: rtl/ernic_rq_cidb_scheduler.sv
// RQ consumer-index doorbell scheduler: coalesces per-QP doorbell updates into a
// pending table and issues RQCI register writes round-robin over valid/ready.
module ernic_rq_cidb_scheduler #(
  parameter int unsigned NUM_QP      = 8,
  parameter int unsigned QP_IDX_W    = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h5004_0200,
  parameter logic [31:0] QP_STRIDE   = 32'h100,
  parameter logic [31:0] CIDB_OFFSET = 32'h34
) (
  input  logic              core_clk,
  input  logic              core_rst_n,
  input  logic              enable,
  input  logic              db_valid,
  input  logic [9:0]        db_addr,
  input  logic [31:0]       db_data,
  output logic              db_rdy,
  output logic              cidb_wr_valid,
  output logic [31:0]       cidb_wr_addr,
  output logic [15:0]       cidb_wr_data,
  input  logic              cidb_wr_rdy,
  output logic [NUM_QP-1:0] pending_vec,
  output logic [15:0]       issued_cnt,
  output logic [15:0]       coalesced_cnt,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                state;
  logic [QP_IDX_W-1:0]   last_grant;
  logic [QP_IDX_W-1:0]   cur_grant;
  logic [15:0]           pend_data [NUM_QP];

  logic [7:0]            db_idx;
  logic [QP_IDX_W-1:0]   db_qp;
  logic                  db_fire;
  logic                  db_ok;
  logic                  gnt_found;
  logic [QP_IDX_W-1:0]   gnt_idx;
  logic [QP_IDX_W-1:0]   cand;
  logic                  grant_now;
  logic                  unused_db;

  assign unused_db = ^db_data[31:16];

  assign db_idx  = db_addr[9:2];
  assign db_qp   = db_idx[QP_IDX_W-1:0];
  assign db_fire = db_valid & db_rdy;
  assign db_ok   = (db_addr[1:0] == 2'b00) && (db_idx != 8'd0) && (32'(db_idx) < NUM_QP);

  // Search upward from the slot after the last completed grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_QP; i++) begin
      cand = last_grant + QP_IDX_W'(i);
      if (!gnt_found && pending_vec[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant_now = (state == StIdle) && enable && gnt_found;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state         <= StIdle;
      last_grant    <= QP_IDX_W'(NUM_QP - 1);
      cur_grant     <= '0;
      cidb_wr_valid <= 1'b0;
      cidb_wr_addr  <= '0;
      cidb_wr_data  <= '0;
      pending_vec   <= '0;
      issued_cnt    <= '0;
      coalesced_cnt <= '0;
      drop_cnt      <= '0;
      db_rdy        <= 1'b0;
      for (int i = 0; i < NUM_QP; i++) pend_data[i] <= '0;
    end else begin
      db_rdy <= 1'b1;

      unique case (state)
        StIdle: begin
          if (grant_now) begin
            cur_grant            <= gnt_idx;
            cidb_wr_addr         <= BASE_ADDR + 32'(gnt_idx) * QP_STRIDE + CIDB_OFFSET;
            cidb_wr_data         <= pend_data[gnt_idx];
            pending_vec[gnt_idx] <= 1'b0;
            cidb_wr_valid        <= 1'b1;
            state                <= StIssue;
          end
        end
        StIssue: begin
          if (cidb_wr_rdy) begin
            cidb_wr_valid <= 1'b0;
            issued_cnt    <= issued_cnt + 16'd1;
            last_grant    <= cur_grant;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      // Accept after the grant clear so a same-cycle update to the granted QP stays pending.
      if (db_fire) begin
        if (db_ok) begin
          pend_data[db_qp]   <= db_data[15:0];
          pending_vec[db_qp] <= 1'b1;
          if (pending_vec[db_qp] && !(grant_now && gnt_idx == db_qp) &&
              coalesced_cnt != 16'hFFFF) begin
            coalesced_cnt <= coalesced_cnt + 16'd1;
          end
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ernic_rq_cidb_scheduler.sv
// Directed bench for ernic_rq_cidb_scheduler with a write-capture monitor.
module tb_ernic_rq_cidb_scheduler;

  logic        core_clk;
  logic        core_rst_n;
  logic        enable;
  logic        db_valid;
  logic [9:0]  db_addr;
  logic [31:0] db_data;
  logic        db_rdy;
  logic        cidb_wr_valid;
  logic [31:0] cidb_wr_addr;
  logic [15:0] cidb_wr_data;
  logic        cidb_wr_rdy;
  logic [7:0]  pending_vec;
  logic [15:0] issued_cnt;
  logic [15:0] coalesced_cnt;
  logic [7:0]  drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] wq_addr [$];
  logic [15:0] wq_data [$];

  ernic_rq_cidb_scheduler dut (
    .core_clk      (core_clk),
    .core_rst_n    (core_rst_n),
    .enable        (enable),
    .db_valid      (db_valid),
    .db_addr       (db_addr),
    .db_data       (db_data),
    .db_rdy        (db_rdy),
    .cidb_wr_valid (cidb_wr_valid),
    .cidb_wr_addr  (cidb_wr_addr),
    .cidb_wr_data  (cidb_wr_data),
    .cidb_wr_rdy   (cidb_wr_rdy),
    .pending_vec   (pending_vec),
    .issued_cnt    (issued_cnt),
    .coalesced_cnt (coalesced_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) begin
    if (core_rst_n && cidb_wr_valid && cidb_wr_rdy) begin
      wq_addr.push_back(cidb_wr_addr);
      wq_data.push_back(cidb_wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_db(input logic [9:0] a, input logic [31:0] d);
    db_valid = 1'b1;
    db_addr  = a;
    db_data  = d;
    @(negedge core_clk);
    db_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int cyc = 0;
    while (wq_addr.size() < n && cyc < 200) begin
      @(negedge core_clk);
      cyc++;
    end
    chk(tag, 32'(wq_addr.size()), 32'(n));
  endtask

  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (cidb_wr_valid !== 1'b1 && cyc < 50) begin
      @(negedge core_clk);
      cyc++;
    end
    chk(tag, {31'd0, cidb_wr_valid}, 32'd1);
  endtask

  task automatic chk_write(input int i, input string tag, input logic [31:0] a,
                           input logic [15:0] d);
    logic [31:0] oa;
    logic [15:0] od;
    oa = (i < wq_addr.size()) ? wq_addr[i] : 32'hDEAD_DEAD;
    od = (i < wq_data.size()) ? wq_data[i] : 16'hDEAD;
    chk({tag, "_addr"}, oa, a);
    chk({tag, "_data"}, {16'd0, od}, {16'd0, d});
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    logic stable;
    core_rst_n  = 1'b0;
    enable      = 1'b0;
    db_valid    = 1'b0;
    db_addr     = '0;
    db_data     = '0;
    cidb_wr_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge core_clk);
    chk("rst_db_rdy", {31'd0, db_rdy}, 32'd0);
    chk("rst_valid", {31'd0, cidb_wr_valid}, 32'd0);
    chk("rst_pending", {24'd0, pending_vec}, 32'd0);
    chk("rst_addr", cidb_wr_addr, 32'd0);
    chk("rst_cnts", {issued_cnt, coalesced_cnt}, 32'd0);
    core_rst_n = 1'b1;
    @(negedge core_clk);
    chk("db_rdy_after_rst", {31'd0, db_rdy}, 32'd1);

    // Round-robin from reset: last_grant=7 so idx1 first
    send_db(10'h004, 32'h11);
    send_db(10'h00C, 32'h33);
    send_db(10'h014, 32'h55);
    chk("rr_pending", {24'd0, pending_vec}, 32'h2A);
    enable = 1'b1;
    wait_writes(3, "rr_nwrites");
    chk_write(0, "rr_w0", 32'h5004_0334, 16'h11);
    chk_write(1, "rr_w1", 32'h5004_0534, 16'h33);
    chk_write(2, "rr_w2", 32'h5004_0734, 16'h55);
    chk("rr_issued", {16'd0, issued_cnt}, 32'd3);

    // Follow-up: last_grant=5, search from 6 wraps to idx1 before idx3
    clear_q();
    enable = 1'b0;
    send_db(10'h00C, 32'h66);
    send_db(10'h004, 32'h77);
    enable = 1'b1;
    wait_writes(2, "rr2_nwrites");
    chk_write(0, "rr2_w0", 32'h5004_0334, 16'h77);
    chk_write(1, "rr2_w1", 32'h5004_0534, 16'h66);

    // Single doorbell with latency: valid high in the second cycle after accept
    clear_q();
    db_valid = 1'b1;
    db_addr  = 10'h004;
    db_data  = 32'h0000_0005;
    @(negedge core_clk);
    db_valid = 1'b0;
    chk("lat_valid_c1", {31'd0, cidb_wr_valid}, 32'd0);
    @(negedge core_clk);
    chk("lat_valid_c2", {31'd0, cidb_wr_valid}, 32'd1);
    wait_writes(1, "single_nwrites");
    chk_write(0, "single_w0", 32'h5004_0334, 16'h0005);
    chk("single_issued", {16'd0, issued_cnt}, 32'd6);
    chk("single_pending", {24'd0, pending_vec}, 32'd0);

    // Coalescing
    clear_q();
    enable = 1'b0;
    send_db(10'h008, 32'd1);
    send_db(10'h008, 32'd2);
    send_db(10'h008, 32'd3);
    chk("coal_cnt", {16'd0, coalesced_cnt}, 32'd2);
    enable = 1'b1;
    wait_writes(1, "coal_nwrites");
    repeat (5) @(negedge core_clk);
    chk("coal_only_one", 32'(wq_addr.size()), 32'd1);
    chk_write(0, "coal_w0", 32'h5004_0434, 16'h0003);
    chk("coal_issued", {16'd0, issued_cnt}, 32'd7);

    // Backpressure with a same-QP doorbell during the wait
    clear_q();
    cidb_wr_rdy = 1'b0;
    send_db(10'h014, 32'hAAAA);
    wait_valid("bp_valid_rise");
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (cidb_wr_valid !== 1'b1 || cidb_wr_addr !== 32'h5004_0734 ||
          cidb_wr_data !== 16'hAAAA) stable = 1'b0;
      if (i == 3) begin
        db_valid = 1'b1;
        db_addr  = 10'h014;
        db_data  = 32'hBBBB;
      end else begin
        db_valid = 1'b0;
      end
      @(negedge core_clk);
    end
    db_valid = 1'b0;
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_pending", {24'd0, pending_vec}, 32'h20);
    cidb_wr_rdy = 1'b1;
    wait_writes(2, "bp_nwrites");
    chk_write(0, "bp_w0", 32'h5004_0734, 16'hAAAA);
    chk_write(1, "bp_w1", 32'h5004_0734, 16'hBBBB);
    chk("bp_coal", {16'd0, coalesced_cnt}, 32'd2);
    chk("bp_issued", {16'd0, issued_cnt}, 32'd9);

    // Invalid addresses
    clear_q();
    send_db(10'h000, 32'h1);
    send_db(10'h006, 32'h2);
    send_db(10'h020, 32'h3);
    repeat (5) @(negedge core_clk);
    chk("inv_drop", {24'd0, drop_cnt}, 32'd3);
    chk("inv_pending", {24'd0, pending_vec}, 32'd0);
    chk("inv_nwrites", 32'(wq_addr.size()), 32'd0);

    // Reset mid-ISSUE
    clear_q();
    enable      = 1'b0;
    cidb_wr_rdy = 1'b0;
    send_db(10'h004, 32'h1);
    send_db(10'h00C, 32'h3);
    enable = 1'b1;
    wait_valid("mid_valid_rise");
    core_rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'd0, cidb_wr_valid}, 32'd0);
    chk("mid_pending", {24'd0, pending_vec}, 32'd0);
    chk("mid_addr_data", cidb_wr_addr | {16'd0, cidb_wr_data}, 32'd0);
    chk("mid_cnts", {issued_cnt, coalesced_cnt}, 32'd0);
    chk("mid_drop_rdy", {23'd0, drop_cnt, db_rdy}, 32'd0);
    @(negedge core_clk);
    core_rst_n  = 1'b1;
    cidb_wr_rdy = 1'b1;
    repeat (10) @(negedge core_clk);
    chk("post_rst_nwrites", 32'(wq_addr.size()), 32'd0);
    chk("post_rst_valid", {31'd0, cidb_wr_valid}, 32'd0);
    chk("post_rst_issued", {16'd0, issued_cnt}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
